rx_desc_ctrl: RTL and testbench
===============================

// Module: rx_desc_ctrl
// PURPOSE
//  Receive counterpart of the TX descriptor path for the 82599 host-bypass datapath.
//  - Owns the RX descriptor ring in a local FPGA BRAM. The NIC DMA-writes packets and write-back descriptors into it.
//  - Initialises the ring, then polls the head descriptor for DD and hands each (buffer addr, len) to the consumer.
//  - Re-arms each consumed descriptor and returns it to the NIC by a PCIe write of RDT.
// PARAMETERS
//  NB_DESC        64  ring entries; power of 2, 2..256
//  BRAM_RD_LAT     2  cycles from addr_o to valid data_i
//  POLL_GAP        8  idle cycles between two DD polls of the same empty slot; 0 = back-to-back
//  DEBUG_EN        0  1 = registered MARK_DEBUG copies of state, head, handshakes
// PORTS
//  clk_i                 in   1    clock; BRAM port clocked from it
//  rst_i_n               in   1    asynchronous active-low reset
//  addr_o                out  32   BRAM byte address, 16 B aligned = {idx,4'b0}
//  clk_o                 out  1    = clk_i
//  data_o                out  128  BRAM write data
//  data_i                in   128  BRAM read data
//  en_o / rst_o          out  1    BRAM enable / BRAM reset
//  wea_o                 out  16   byte write enables
//  wren_o                out  1    write strobe (Intel BRAM)
//  start_i               in   1    1 = polling and delivery allowed
//  init_i                in   1    synchronous re-initialise request (level)
//  nic_base_addr_i       in   32   NIC BAR0 base
//  fpga_base_addr_i      in   32   FPGA packet memory base as seen by the NIC
//  pkt_addr_o            out  32   buffer offset of received packet (idx*2048)
//  pkt_len_o             out  16   PKT_LEN from write-back
//  pkt_err_o             out  1    1 = RXE error bits set, or EOP=0
//  rcv_valid_o           out  1    packet available
//  rcv_ack_i             in   1    consumer done with the buffer
//  nic_phys_addr_o       out  64   NIC register address for PCIe write
//  nic_rx_tail_pointer_o out  32   RDT value to write
//  pcie_rq_start_o       out  1    PCIe write request, level
//  pcie_rq_ack_i         in   1    PCIe write accepted
// BEHAVIOUR
//  Reset (rst_i_n=0), asynchronous:
//   - All outputs 0, except rst_o=1. State=RESET, head=0, poll counter=0.
//   - Internal init flag=1, released synchronously one cycle after rst_i_n=1 and init_i=0.
//  Read descriptor: {64'h0, 32'h0, buf_addr}. buf_addr = fpga_base_addr_i | idx*2048. Bit 64 (DD) = 0.
//  Write-back fields:
//   - DD = data_i[64], EOP = data_i[65]
//   - RXE = data_i[95:84] != 0
//   - PKT_LEN = data_i[111:96]
//  RDT_REG_OFFS = 64'h1018 (queue 0). nic_phys_addr_o = nic_base_addr_i + RDT_REG_OFFS.
//  States:
//   - RESET: write the read descriptor to idx 0..NB_DESC-1, one per cycle (wea_o=FFFF, wren_o=1).
//     After NB_DESC-1 -> INIT_RDT.
//   - INIT_RDT: RDT=NB_DESC-1, pcie_rq_start_o=1; hold until pcie_rq_ack_i -> POLL.
//     The ring never goes full-owned: one slot always stays with SW.
//   - POLL: requires start_i=1 and poll counter=0. addr_o={head,4'b0}, wait BRAM_RD_LAT -> CHECK.
//   - CHECK, DD=0: reload counter with POLL_GAP -> POLL.
//   - CHECK, DD=1: latch pkt_addr_o=head*2048, pkt_len_o, pkt_err_o=RXE|~EOP; set rcv_valid_o=1 -> DELIVER.
//   - DELIVER: hold outputs stable until rcv_ack_i=1 (ack may arrive in the first valid cycle).
//     Then rcv_valid_o=0 -> REARM.
//   - REARM: write the read descriptor for head; RDT value=head; head=head+1 mod NB_DESC -> PCIE_WRITE_RDT.
//   - PCIE_WRITE_RDT: pcie_rq_start_o=1 -> PCIE_WAIT_RDT.
//   - PCIE_WAIT_RDT: on pcie_rq_ack_i, pcie_rq_start_o=0 -> POLL.
//  Delivery latency, DD visible to rcv_valid_o: BRAM_RD_LAT+1 cycles.
//  Rules:
//   - Rearm only after ack; the buffer is never handed back to the NIC while the consumer holds it.
//   - Only one PCIe request is outstanding at a time.
//   - start_i=0 blocks new POLLs only; DELIVER/REARM/PCIe sequences in flight complete.
//   - init_i=1 in any state: next cycle, rcv_valid_o=0, pcie_rq_start_o=0, head=0, state RESET.
//     The unacked packet is dropped.
//   - Head wraps NB_DESC-1 -> 0. pkt_err packets are still delivered and re-armed.
//   - en_o=1 whenever not in init.
// STRUCTURE
//  Shared package/include rx_tx_desc_pkg:
//   - TDT/RDT register offsets
//   - descriptor field bit positions (DD, EOP, RXE, PKT_LEN, DTYP)
//   - RX buffer stride 2048; TX buffer region offset 256*2048
//  Single FSM plus head/poll counters.
//  Sub-module rx_bram_rd_pipe: BRAM_RD_LAT-deep valid shift register, so latency stays parameterisable.
// TESTING
//  1. Init, NB_DESC=4, fpga_base=0x8000_0000.
//     -> Writes idx0..3 with addr 0x8000_0000/0800/1000/1800, bit64=0.
//     -> Then PCIe RDT=3 to nic_base+0x1018.
//  2. Model writes idx0 with DD=1, EOP=1, len=60.
//     -> rcv_valid_o after 3 cycles, pkt_addr_o=0, len=60, err=0.
//     -> Ack -> rearm idx0, RDT=0.
//  3. Completions on idx3 then idx0 -> pkt_addr_o 0x1800 then 0x0; head wraps; RDT values 3 then 0.
//  4. rcv_ack_i withheld 100 cycles -> no BRAM write to that idx, no PCIe request, outputs stable.
//  5. DD=1, EOP=0, RXE=0x001 -> pkt_err_o=1; still re-armed.
//  6. init_i pulsed in DELIVER -> rcv_valid_o=0 next cycle, full re-init, RDT=NB_DESC-1 rewritten.
//  7. start_i=0 -> no POLLs.

Source files
------------

// File: rtl/rx_tx_desc_pkg.sv
// Shared RX/TX descriptor definitions for the 82599 host-bypass datapath.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package rx_tx_desc_pkg;

  // Queue-0 tail register offsets within NIC BAR0
  localparam logic [63:0] TDT_REG_OFFS = 64'h6018;
  localparam logic [63:0] RDT_REG_OFFS = 64'h1018;

  // Descriptor field bit positions (128-bit descriptor)
  localparam int DESC_DD_BIT   = 64;
  localparam int DESC_EOP_BIT  = 65;
  localparam int DESC_RXE_LSB  = 84;
  localparam int DESC_RXE_MSB  = 95;
  localparam int DESC_LEN_LSB  = 96;
  localparam int DESC_LEN_MSB  = 111;
  localparam int DESC_DTYP_LSB = 84;
  localparam int DESC_DTYP_MSB = 87;

  // Packet buffer layout: one 2 KiB buffer per RX slot, TX region above 256 RX slots
  localparam int RX_BUF_SHIFT  = 11;
  localparam int RX_BUF_STRIDE = 1 << RX_BUF_SHIFT;
  localparam int TX_BUF_OFFS   = 256 * RX_BUF_STRIDE;

  // RX write-back view of a descriptor, MSB first
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [15:0] pkt_len;
    logic [11:0] rxe;
    logic [17:0] rsvd_mid;
    logic        eop;
    logic        dd;
    logic [63:0] lo;
  } rx_wb_t;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT_RDT,
    ST_POLL,
    ST_CHECK,
    ST_DELIVER,
    ST_REARM,
    ST_PCIE_WRITE_RDT,
    ST_PCIE_WAIT_RDT
  } rx_state_e;

  // Byte offset of the packet buffer that belongs to ring slot idx
  function automatic logic [31:0] rx_buf_offs(input logic [7:0] idx);
    return 32'(idx) << RX_BUF_SHIFT;
  endfunction

  // Read-format descriptor handed to the NIC: only the buffer address, DD clear
  function automatic logic [127:0] rx_read_desc(input logic [31:0] base, input logic [7:0] idx);
    return {64'h0, 32'h0, base | rx_buf_offs(idx)};
  endfunction

endpackage

// File: rtl/rx_bram_rd_pipe.sv
// Tracks an in-flight BRAM read so the FSM knows when read data is valid.
// Latency: o_vld follows i_req by exactly LAT cycles.
// Backpressure: none; every request produces one valid pulse unless cleared.
module rx_bram_rd_pipe
  import rx_tx_desc_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_req,
  output logic o_vld
);

  logic [LAT-1:0] r_sr;

  // Shift the request marker along; a clear drops reads issued before re-init
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr <= (r_sr << 1) | LAT'(i_req);
    end
  end

  assign o_vld = r_sr[LAT-1];

endmodule

// File: rtl/rx_desc_ctrl.sv
// RX descriptor ring owner: init ring, poll head DD, deliver buffer, re-arm and bump RDT.
// Latency: poll address to rcv_valid_o is BRAM_RD_LAT+1 cycles.
// Backpressure: holds rcv_valid_o until rcv_ack_i; holds pcie_rq_start_o until pcie_rq_ack_i.
module rx_desc_ctrl
  import rx_tx_desc_pkg::*;
#(
  parameter int NB_DESC     = 64,
  parameter int BRAM_RD_LAT = 2,
  parameter int POLL_GAP    = 8,
  parameter bit DEBUG_EN    = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i_n,
  output logic [31:0]  addr_o,
  output logic         clk_o,
  output logic [127:0] data_o,
  input  logic [127:0] data_i,
  output logic         en_o,
  output logic         rst_o,
  output logic [15:0]  wea_o,
  output logic         wren_o,
  input  logic         start_i,
  input  logic         init_i,
  input  logic [31:0]  nic_base_addr_i,
  input  logic [31:0]  fpga_base_addr_i,
  output logic [31:0]  pkt_addr_o,
  output logic [15:0]  pkt_len_o,
  output logic         pkt_err_o,
  output logic         rcv_valid_o,
  input  logic         rcv_ack_i,
  output logic [63:0]  nic_phys_addr_o,
  output logic [31:0]  nic_rx_tail_pointer_o,
  output logic         pcie_rq_start_o,
  input  logic         pcie_rq_ack_i
);

  localparam int IDX_W = (NB_DESC > 1) ? $clog2(NB_DESC) : 1;
  localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_DESC - 1);

  rx_state_e          r_state;
  logic               r_init;
  logic [IDX_W-1:0]   r_head;
  logic [IDX_W-1:0]   r_idx;
  logic [GAP_W-1:0]   r_poll_cnt;
  logic [31:0]        r_addr;
  logic [127:0]       r_wdat;
  logic [15:0]        r_wea;
  logic               r_wren;
  logic               r_rd_req;
  logic [31:0]        r_pkt_addr;
  logic [15:0]        r_pkt_len;
  logic               r_pkt_err;
  logic               r_rcv_vld;
  logic [63:0]        r_phys;
  logic [31:0]        r_rdt;
  logic               r_rq_start;

  rx_wb_t             w_wb;
  logic               w_rxe;
  logic               w_rd_vld;
  logic               w_pipe_clr;
  logic [127:0]       w_desc_idx;
  logic [127:0]       w_desc_head;
  logic [63:0]        w_phys;
  logic               w_unused_wb;

  assign w_wb        = rx_wb_t'(data_i);
  assign w_rxe       = |w_wb.rxe;
  assign w_desc_idx  = rx_read_desc(fpga_base_addr_i, 8'(r_idx));
  assign w_desc_head = rx_read_desc(fpga_base_addr_i, 8'(r_head));
  assign w_phys      = {32'h0, nic_base_addr_i} + RDT_REG_OFFS;
  assign w_pipe_clr  = init_i | r_init;
  assign w_unused_wb = ^{w_wb.rsvd_hi, w_wb.rsvd_mid, w_wb.lo};

  rx_bram_rd_pipe #(
    .LAT (BRAM_RD_LAT)
  ) u_rd_pipe (
    .i_clk   (clk_i),
    .i_rst_n (rst_i_n),
    .i_clr   (w_pipe_clr),
    .i_req   (r_rd_req),
    .o_vld   (w_rd_vld)
  );

  // Init flag: asserted by reset, then simply tracks the init_i level one cycle late
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      r_init <= 1'b1;
    end else begin
      r_init <= init_i;
    end
  end

  // Main FSM with head/poll counters; all BRAM, delivery and PCIe outputs are registered here
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      r_state    <= ST_RESET;
      r_head     <= '0;
      r_idx      <= '0;
      r_poll_cnt <= '0;
      r_addr     <= '0;
      r_wdat     <= '0;
      r_wea      <= '0;
      r_wren     <= 1'b0;
      r_rd_req   <= 1'b0;
      r_pkt_addr <= '0;
      r_pkt_len  <= '0;
      r_pkt_err  <= 1'b0;
      r_rcv_vld  <= 1'b0;
      r_phys     <= '0;
      r_rdt      <= '0;
      r_rq_start <= 1'b0;
    end else begin
      r_wren   <= 1'b0;
      r_wea    <= '0;
      r_rd_req <= 1'b0;
      if (init_i || r_init) begin
        // Any pending delivery or PCIe request is abandoned; the ring is rebuilt from scratch
        r_state    <= ST_RESET;
        r_head     <= '0;
        r_idx      <= '0;
        r_poll_cnt <= '0;
        r_rcv_vld  <= 1'b0;
        r_rq_start <= 1'b0;
      end else begin
        case (r_state)
          ST_RESET: begin
            r_addr <= 32'({r_idx, 4'b0000});
            r_wdat <= w_desc_idx;
            r_wea  <= '1;
            r_wren <= 1'b1;
            r_idx  <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              // One slot stays with SW so the ring never looks full-owned to the NIC
              r_rdt      <= 32'(LAST_IDX);
              r_phys     <= w_phys;
              r_rq_start <= 1'b1;
              r_state    <= ST_INIT_RDT;
            end
          end
          ST_INIT_RDT: begin
            if (pcie_rq_ack_i) begin
              r_rq_start <= 1'b0;
              r_state    <= ST_POLL;
            end
          end
          ST_POLL: begin
            if (r_poll_cnt != '0) begin
              r_poll_cnt <= r_poll_cnt - 1'b1;
            end else if (start_i) begin
              r_addr   <= 32'({r_head, 4'b0000});
              r_rd_req <= 1'b1;
              r_state  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (w_rd_vld) begin
              if (w_wb.dd) begin
                r_pkt_addr <= rx_buf_offs(8'(r_head));
                r_pkt_len  <= w_wb.pkt_len;
                r_pkt_err  <= w_rxe | ~w_wb.eop;
                r_rcv_vld  <= 1'b1;
                r_state    <= ST_DELIVER;
              end else begin
                r_poll_cnt <= GAP_W'(POLL_GAP);
                r_state    <= ST_POLL;
              end
            end
          end
          ST_DELIVER: begin
            if (rcv_ack_i) begin
              r_rcv_vld <= 1'b0;
              r_state   <= ST_REARM;
            end
          end
          ST_REARM: begin
            // Buffer is released by the consumer, so it is safe to give the slot back
            r_addr  <= 32'({r_head, 4'b0000});
            r_wdat  <= w_desc_head;
            r_wea   <= '1;
            r_wren  <= 1'b1;
            r_rdt   <= 32'(r_head);
            r_head  <= r_head + 1'b1;
            r_state <= ST_PCIE_WRITE_RDT;
          end
          ST_PCIE_WRITE_RDT: begin
            r_phys     <= w_phys;
            r_rq_start <= 1'b1;
            r_state    <= ST_PCIE_WAIT_RDT;
          end
          ST_PCIE_WAIT_RDT: begin
            if (pcie_rq_ack_i) begin
              r_rq_start <= 1'b0;
              r_state    <= ST_POLL;
            end
          end
          default: begin
            r_state <= ST_RESET;
          end
        endcase
      end
    end
  end

  assign clk_o                 = clk_i;
  assign rst_o                 = r_init;
  assign en_o                  = ~r_init;
  assign addr_o                = r_addr;
  assign data_o                = r_wdat;
  assign wea_o                 = r_wea;
  assign wren_o                = r_wren;
  assign pkt_addr_o            = r_pkt_addr;
  assign pkt_len_o             = r_pkt_len;
  assign pkt_err_o             = r_pkt_err;
  assign rcv_valid_o           = r_rcv_vld;
  assign nic_phys_addr_o       = r_phys;
  assign nic_rx_tail_pointer_o = r_rdt;
  assign pcie_rq_start_o       = r_rq_start;

  generate
    if (DEBUG_EN) begin : g_dbg
      (* mark_debug = "true" *) rx_state_e        r_dbg_state;
      (* mark_debug = "true" *) logic [IDX_W-1:0] r_dbg_head;
      (* mark_debug = "true" *) logic [3:0]       r_dbg_hs;

      // Registered probe copies so debug taps do not load the functional paths
      always_ff @(posedge clk_i or negedge rst_i_n) begin
        if (!rst_i_n) begin
          r_dbg_state <= ST_RESET;
          r_dbg_head  <= '0;
          r_dbg_hs    <= '0;
        end else begin
          r_dbg_state <= r_state;
          r_dbg_head  <= r_head;
          r_dbg_hs    <= {r_rcv_vld, rcv_ack_i, r_rq_start, pcie_rq_ack_i};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rx_desc_ctrl.sv
// Directed bench for rx_desc_ctrl with a 4-entry ring and a 2-cycle BRAM model.
// Latency: n/a.
// Backpressure: bench acks PCIe one cycle after request; consumer ack is scripted.
module tb_rx_desc_ctrl;

  localparam int NB = 4;
  localparam logic [31:0] FPGA_BASE = 32'h8000_0000;
  localparam logic [31:0] NIC_BASE  = 32'hF000_0000;
  localparam logic [63:0] EXP_PHYS  = 64'h0000_0000_F000_1018;

  logic         clk_i = 1'b0;
  logic         rst_i_n;
  logic [31:0]  addr_o;
  logic         clk_o;
  logic [127:0] data_o;
  logic [127:0] data_i;
  logic         en_o, rst_o;
  logic [15:0]  wea_o;
  logic         wren_o;
  logic         start_i, init_i;
  logic [31:0]  pkt_addr_o;
  logic [15:0]  pkt_len_o;
  logic         pkt_err_o, rcv_valid_o, rcv_ack_i;
  logic [63:0]  nic_phys_addr_o;
  logic [31:0]  nic_rx_tail_pointer_o;
  logic         pcie_rq_start_o, pcie_rq_ack_i;

  rx_desc_ctrl #(
    .NB_DESC(NB), .BRAM_RD_LAT(2), .POLL_GAP(4), .DEBUG_EN(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i_n(rst_i_n), .addr_o(addr_o), .clk_o(clk_o),
    .data_o(data_o), .data_i(data_i), .en_o(en_o), .rst_o(rst_o),
    .wea_o(wea_o), .wren_o(wren_o), .start_i(start_i), .init_i(init_i),
    .nic_base_addr_i(NIC_BASE), .fpga_base_addr_i(FPGA_BASE),
    .pkt_addr_o(pkt_addr_o), .pkt_len_o(pkt_len_o), .pkt_err_o(pkt_err_o),
    .rcv_valid_o(rcv_valid_o), .rcv_ack_i(rcv_ack_i),
    .nic_phys_addr_o(nic_phys_addr_o), .nic_rx_tail_pointer_o(nic_rx_tail_pointer_o),
    .pcie_rq_start_o(pcie_rq_start_o), .pcie_rq_ack_i(pcie_rq_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // BRAM model (2-cycle read) plus NIC-side write port and write/PCIe logs
  logic [127:0] mem [NB];
  logic [127:0] rd_p1, rd_p2;
  int           wr_cnt [NB];
  int           wr_total = 0;
  int           pcie_cnt = 0;
  logic [31:0]  last_rdt = '0;
  logic [63:0]  last_phys = '0;
  logic         nic_wr_vld = 1'b0;
  logic [1:0]   nic_wr_idx = '0;
  logic [127:0] nic_wr_dat = '0;

  assign data_i = rd_p2;

  always @(posedge clk_i) begin
    if (en_o) begin
      rd_p1 <= mem[addr_o[5:4]];
      if (wren_o) begin
        for (int b = 0; b < 16; b++)
          if (wea_o[b]) mem[addr_o[5:4]][8*b +: 8] <= data_o[8*b +: 8];
        wr_cnt[addr_o[5:4]] <= wr_cnt[addr_o[5:4]] + 1;
        wr_total <= wr_total + 1;
      end
    end
    rd_p2 <= rd_p1;
    if (nic_wr_vld) mem[nic_wr_idx] <= nic_wr_dat;
    if (pcie_rq_start_o && pcie_rq_ack_i) begin
      pcie_cnt  <= pcie_cnt + 1;
      last_rdt  <= nic_rx_tail_pointer_o;
      last_phys <= nic_phys_addr_o;
    end
  end

  // PCIe completer: accept each request one cycle after it appears
  initial begin
    pcie_rq_ack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      pcie_rq_ack_i = pcie_rq_start_o;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] exp_desc(input int i);
    return {96'h0, FPGA_BASE + 32'(i) * 32'h0000_0800};
  endfunction

  function automatic logic [127:0] wb_desc(input logic eop, input logic [11:0] rxe, input logic [15:0] len);
    return {16'hABCD, len, rxe, 18'h0, eop, 1'b1, 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic nic_write(input int idx, input logic [127:0] d);
    @(negedge clk_i);
    nic_wr_idx = 2'(idx);
    nic_wr_dat = d;
    nic_wr_vld = 1'b1;
    @(negedge clk_i);
    nic_wr_vld = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (rcv_valid_o !== 1'b1 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check(name, rcv_valid_o, 1);
  endtask

  task automatic wait_pcie(input string name, input int snap);
    int n = 0;
    while (pcie_cnt == snap && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    check(name, pcie_cnt, snap + 1);
  endtask

  typedef struct {
    int          idx;
    logic        eop;
    logic [11:0] rxe;
    logic [15:0] len;
    int          hold;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic [31:0] exp_rdt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          snap_p, snap_w;
    int          snap_cnt [NB];
    bit          stable;
    logic [31:0] h_addr;
    logic [15:0] h_len;
    logic        h_err;

    vecs[0] = '{0, 1'b1, 12'h000, 16'd60,   0,   32'h0000_0000, 1'b0, 32'd0};
    vecs[1] = '{1, 1'b0, 12'h001, 16'd1514, 100, 32'h0000_0800, 1'b1, 32'd1};
    vecs[2] = '{2, 1'b1, 12'h800, 16'd9000, 3,   32'h0000_1000, 1'b1, 32'd2};
    vecs[3] = '{3, 1'b0, 12'h000, 16'd64,   0,   32'h0000_1800, 1'b1, 32'd3};
    vecs[4] = '{0, 1'b1, 12'h000, 16'd128,  2,   32'h0000_0000, 1'b0, 32'd0};

    rst_i_n = 1'b0; start_i = 1'b0; init_i = 1'b0; rcv_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_rst_o", rst_o, 1);
    check("rst_en_o", en_o, 0);
    check("rst_wren", wren_o, 0);
    check("rst_valid", rcv_valid_o, 0);
    check("rst_rq_start", pcie_rq_start_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_rdt", nic_rx_tail_pointer_o, 0);

    // Ring initialisation followed by RDT=NB-1
    rst_i_n = 1'b1;
    wait_pcie("init_pcie", 0);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("init_wr_cnt%0d", i), wr_cnt[i], 1);
      check($sformatf("init_desc%0d", i), mem[i], exp_desc(i));
    end
    check("init_rdt", last_rdt, 32'd3);
    check("init_phys", last_phys, EXP_PHYS);
    check("init_en_o", en_o, 1);

    // start_i low: a completed slot must not be polled
    nic_write(0, wb_desc(1'b1, 12'h000, 16'd60));
    repeat (40) @(negedge clk_i);
    check("nostart_valid", rcv_valid_o, 0);
    check("nostart_addr", addr_o, 32'h30);

    // Poll address to rcv_valid_o latency
    start_i = 1'b1;
    @(negedge clk_i);
    check("lat_poll_addr", addr_o, 32'h0);
    repeat (2) @(negedge clk_i);
    check("lat_valid_early", rcv_valid_o, 0);
    @(negedge clk_i);
    check("lat_valid", rcv_valid_o, 1);

    for (int v = 0; v < 5; v++) begin
      nic_write(vecs[v].idx, wb_desc(vecs[v].eop, vecs[v].rxe, vecs[v].len));
      wait_valid($sformatf("v%0d_valid", v));
      check($sformatf("v%0d_pkt_addr", v), pkt_addr_o, vecs[v].exp_addr);
      check($sformatf("v%0d_pkt_len", v), pkt_len_o, vecs[v].len);
      check($sformatf("v%0d_pkt_err", v), pkt_err_o, vecs[v].exp_err);
      snap_p = pcie_cnt; snap_w = wr_total;
      h_addr = pkt_addr_o; h_len = pkt_len_o; h_err = pkt_err_o;
      stable = 1'b1;
      for (int c = 0; c < vecs[v].hold; c++) begin
        @(negedge clk_i);
        if (rcv_valid_o !== 1'b1 || pkt_addr_o !== h_addr || pkt_len_o !== h_len ||
            pkt_err_o !== h_err || wr_total != snap_w || pcie_cnt != snap_p ||
            pcie_rq_start_o !== 1'b0)
          stable = 1'b0;
      end
      check($sformatf("v%0d_hold_stable", v), stable, 1);
      snap_w = wr_cnt[vecs[v].idx];
      rcv_ack_i = 1'b1;
      @(negedge clk_i);
      rcv_ack_i = 1'b0;
      check($sformatf("v%0d_valid_drop", v), rcv_valid_o, 0);
      wait_pcie($sformatf("v%0d_pcie", v), snap_p);
      check($sformatf("v%0d_rdt", v), last_rdt, vecs[v].exp_rdt);
      check($sformatf("v%0d_phys", v), last_phys, EXP_PHYS);
      check($sformatf("v%0d_rearm_cnt", v), wr_cnt[vecs[v].idx], snap_w + 1);
      check($sformatf("v%0d_rearm_desc", v), mem[vecs[v].idx], exp_desc(vecs[v].idx));
    end

    // init_i pulsed while a packet is being delivered
    nic_write(1, wb_desc(1'b1, 12'h000, 16'd200));
    wait_valid("reinit_valid");
    check("reinit_pkt_addr", pkt_addr_o, 32'h0000_0800);
    snap_p = pcie_cnt;
    for (int i = 0; i < NB; i++) snap_cnt[i] = wr_cnt[i];
    init_i = 1'b1;
    @(negedge clk_i);
    init_i = 1'b0;
    check("reinit_valid_drop", rcv_valid_o, 0);
    check("reinit_rq_start", pcie_rq_start_o, 0);
    check("reinit_rst_o", rst_o, 1);
    wait_pcie("reinit_pcie", snap_p);
    check("reinit_rdt", last_rdt, 32'd3);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("reinit_wr_cnt%0d", i), wr_cnt[i], snap_cnt[i] + 1);
      check($sformatf("reinit_desc%0d", i), mem[i], exp_desc(i));
    end
    repeat (30) @(negedge clk_i);
    check("reinit_dropped", rcv_valid_o, 0);
    nic_write(0, wb_desc(1'b1, 12'h000, 16'd77));
    wait_valid("reinit_head0_valid");
    check("reinit_head0_addr", pkt_addr_o, 32'h0);
    check("reinit_head0_len", pkt_len_o, 16'd77);
    rcv_ack_i = 1'b1;
    @(negedge clk_i);
    rcv_ack_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
